// File: rtl/am_demod_arbiter.sv
// rtl/am_demod_arbiter.sv - round-robin scheduler sharing one AM magnitude demodulator across NCH I/Q channels
// Optional per-channel saturating overrun counters: define AM_ARB_OVERRUN_CNT_EN.
module am_demod_arbiter #(
    parameter int NCH     = 4,
    parameter int BITS_IN = 8,
    parameter int BITS    = 16,
    parameter int TIMEOUT = 127,
    parameter int CH_W    = $clog2(NCH)
) (
    input  logic                   CLK,
    input  logic                   RSTb,
    input  logic [NCH*BITS_IN-1:0] ch_I,
    input  logic [NCH*BITS_IN-1:0] ch_Q,
    input  logic [NCH-1:0]         ch_tick,
    output logic [BITS_IN-1:0]     demod_I,
    output logic [BITS_IN-1:0]     demod_Q,
    output logic                   demod_load_tick,
    output logic                   demod_rstb,
    input  logic [BITS-1:0]        demod_in,
    input  logic                   demod_tick,
    output logic [BITS-1:0]        out_sample,
    output logic [CH_W-1:0]        out_ch,
    output logic                   out_valid,
    output logic [NCH-1:0]         overrun,
    input  logic                   clear_overrun,
    output logic                   timeout_err,
    output logic                   busy,
    output logic [NCH*8-1:0]       overrun_cnt
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT);
    localparam logic [TW-1:0] T_ONE = TW'(1);
    localparam logic [CH_W:0] NCH_V = (CH_W + 1)'(NCH);
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NCH - 1);

    typedef enum logic [2:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_WAIT,
        ARB_DELIVER,
        ARB_RECOVER
    } arb_state_t;

    arb_state_t state, state_d;
    logic [TW-1:0] timer, timer_d;
    logic [CH_W-1:0] last_grant, last_grant_d;
    logic [NCH-1:0] pending, pending_d, granted, ovr_event, overrun_d;
    logic [BITS_IN-1:0] hold_I [NCH];
    logic [BITS_IN-1:0] hold_Q [NCH];
    logic [BITS_IN-1:0] demod_I_d, demod_Q_d;
    logic [BITS-1:0] out_sample_d;
    logic [CH_W-1:0] out_ch_d;
    logic load_d, rstb_q, rstb_d, out_valid_d, timeout_d;
    logic grant_fire, found;
    logic [CH_W-1:0] win;
    logic [CH_W:0] idx;

    // Search starts one past the last grant so every pending channel is reached within NCH grants.
    always_comb begin
        win   = last_grant;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= NCH; i++) begin
            idx = {1'b0, last_grant} + (CH_W + 1)'(i);
            if (idx >= NCH_V) idx = idx - NCH_V;
            if (!found && pending[idx[CH_W-1:0]]) begin
                found = 1'b1;
                win   = idx[CH_W-1:0];
            end
        end
    end

    always_comb begin
        state_d      = state;
        timer_d      = timer;
        last_grant_d = last_grant;
        demod_I_d    = demod_I;
        demod_Q_d    = demod_Q;
        load_d       = 1'b0;
        rstb_d       = rstb_q;
        out_sample_d = out_sample;
        out_ch_d     = out_ch;
        out_valid_d  = 1'b0;
        timeout_d    = 1'b0;
        grant_fire   = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (found) begin
                    grant_fire   = 1'b1;
                    demod_I_d    = hold_I[win];
                    demod_Q_d    = hold_Q[win];
                    last_grant_d = win;
                    state_d      = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                load_d  = 1'b1;
                timer_d = '0;
                state_d = ARB_WAIT;
            end
            ARB_WAIT: begin
                if (demod_tick) begin
                    out_sample_d = demod_in;
                    out_ch_d     = last_grant;
                    state_d      = ARB_DELIVER;
                end else if (timer == T_MAX) begin
                    timeout_d = 1'b1;
                    rstb_d    = 1'b0;
                    timer_d   = '0;
                    state_d   = ARB_RECOVER;
                end else begin
                    timer_d = timer + T_ONE;
                end
            end
            ARB_DELIVER: begin
                out_valid_d = 1'b1;
                state_d     = ARB_IDLE;
            end
            ARB_RECOVER: begin
                // Demodulator reset is held low for two cycles; the timed-out sample is dropped.
                if (timer == T_ONE) begin
                    rstb_d  = 1'b1;
                    state_d = ARB_IDLE;
                end else begin
                    timer_d = timer + T_ONE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // A tick on the channel being granted refills its slot without counting as an overrun.
    always_comb begin
        granted = '0;
        if (grant_fire) granted[win] = 1'b1;
        ovr_event = ch_tick & pending & ~granted;
        pending_d = ch_tick | (pending & ~granted);
        overrun_d = (clear_overrun ? '0 : overrun) | ovr_event;
    end

    always_ff @(posedge CLK) begin
        if (!RSTb) begin
            state           <= ARB_IDLE;
            timer           <= '0;
            last_grant      <= LAST_CH;
            pending         <= '0;
            overrun         <= '0;
            demod_I         <= '0;
            demod_Q         <= '0;
            demod_load_tick <= 1'b0;
            rstb_q          <= 1'b1;
            out_sample      <= '0;
            out_ch          <= '0;
            out_valid       <= 1'b0;
            timeout_err     <= 1'b0;
            busy            <= 1'b0;
        end else begin
            state           <= state_d;
            timer           <= timer_d;
            last_grant      <= last_grant_d;
            pending         <= pending_d;
            overrun         <= overrun_d;
            demod_I         <= demod_I_d;
            demod_Q         <= demod_Q_d;
            demod_load_tick <= load_d;
            rstb_q          <= rstb_d;
            out_sample      <= out_sample_d;
            out_ch          <= out_ch_d;
            out_valid       <= out_valid_d;
            timeout_err     <= timeout_d;
            busy            <= (state_d != ARB_IDLE);
        end
    end

    always_ff @(posedge CLK) begin
        for (int k = 0; k < NCH; k++) begin
            if (!RSTb) begin
                hold_I[k] <= '0;
                hold_Q[k] <= '0;
            end else if (ch_tick[k]) begin
                hold_I[k] <= ch_I[k*BITS_IN +: BITS_IN];
                hold_Q[k] <= ch_Q[k*BITS_IN +: BITS_IN];
            end
        end
    end

    // The demodulator is also held in reset while the arbiter itself is in reset.
    assign demod_rstb = rstb_q & RSTb;

`ifdef AM_ARB_OVERRUN_CNT_EN
    logic [7:0] ovr_cnt [NCH];

    always_ff @(posedge CLK) begin
        for (int k = 0; k < NCH; k++) begin
            if (!RSTb) begin
                ovr_cnt[k] <= '0;
            end else if (clear_overrun) begin
                ovr_cnt[k] <= {7'd0, ovr_event[k]};
            end else if (ovr_event[k] && (ovr_cnt[k] != 8'hFF)) begin
                ovr_cnt[k] <= ovr_cnt[k] + 8'd1;
            end
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_cnt_out
        assign overrun_cnt[g*8 +: 8] = ovr_cnt[g];
    end
`else
    assign overrun_cnt = '0;
`endif

endmodule

// File: tb/tb_am_demod_arbiter.sv
// tb/tb_am_demod_arbiter.sv - scoreboard bench for am_demod_arbiter with a behavioural demodulator
module tb_am_demod_arbiter;
    localparam int NCH     = 4;
    localparam int BITS_IN = 8;
    localparam int BITS    = 16;
    localparam int TIMEOUT = 127;
    localparam int CH_W    = 2;
    localparam int D       = 40;

    logic                   CLK = 1'b0;
    logic                   RSTb;
    logic [NCH*BITS_IN-1:0] ch_I, ch_Q;
    logic [NCH-1:0]         ch_tick;
    logic [BITS_IN-1:0]     demod_I, demod_Q;
    logic                   demod_load_tick, demod_rstb;
    logic [BITS-1:0]        demod_in;
    logic                   demod_tick;
    logic [BITS-1:0]        out_sample;
    logic [CH_W-1:0]        out_ch;
    logic                   out_valid;
    logic [NCH-1:0]         overrun;
    logic                   clear_overrun;
    logic                   timeout_err, busy;
    logic [NCH*8-1:0]       overrun_cnt;

    am_demod_arbiter #(
        .NCH(NCH), .BITS_IN(BITS_IN), .BITS(BITS), .TIMEOUT(TIMEOUT), .CH_W(CH_W)
    ) dut (
        .CLK(CLK), .RSTb(RSTb), .ch_I(ch_I), .ch_Q(ch_Q), .ch_tick(ch_tick),
        .demod_I(demod_I), .demod_Q(demod_Q), .demod_load_tick(demod_load_tick),
        .demod_rstb(demod_rstb), .demod_in(demod_in), .demod_tick(demod_tick),
        .out_sample(out_sample), .out_ch(out_ch), .out_valid(out_valid),
        .overrun(overrun), .clear_overrun(clear_overrun), .timeout_err(timeout_err),
        .busy(busy), .overrun_cnt(overrun_cnt)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [CH_W-1:0] ch;
        logic [BITS-1:0] mag;
    } exp_t;

    exp_t exp_q[$];
    int n_cmp = 0;
    int n_err = 0;
    logic demod_hang = 1'b0;
    logic flood = 1'b0;
    logic [BITS-1:0] flood_exp = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [BITS-1:0] mag_of(input logic [BITS_IN-1:0] i, input logic [BITS_IN-1:0] q);
        int ai, aq;
        ai = int'($signed(i));
        aq = int'($signed(q));
        if (ai < 0) ai = -ai;
        if (aq < 0) aq = -aq;
        return BITS'(ai + aq);
    endfunction

    task automatic set_s(input int k, input logic [BITS_IN-1:0] i, input logic [BITS_IN-1:0] q);
        ch_I[k*BITS_IN +: BITS_IN] = i;
        ch_Q[k*BITS_IN +: BITS_IN] = q;
    endtask

    task automatic push(input int k, input logic [BITS_IN-1:0] i, input logic [BITS_IN-1:0] q);
        exp_t e;
        e.ch  = CH_W'(k);
        e.mag = mag_of(i, q);
        exp_q.push_back(e);
    endtask

    task automatic pulse(input logic [NCH-1:0] m);
        ch_tick = m;
        @(posedge CLK); #1;
        ch_tick = '0;
    endtask

    task automatic do_reset();
        RSTb = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_demod_rstb_low", 32'(demod_rstb), 0);
        RSTb = 1'b1;
        @(posedge CLK); #1;
    endtask

    task automatic wait_drain(input int limit);
        int n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            @(posedge CLK); #1;
            n++;
        end
        check("drain", 32'(exp_q.size()), 0);
        repeat (2) @(posedge CLK);
        #1;
    endtask

    task automatic clear_flags();
        clear_overrun = 1'b1;
        @(posedge CLK); #1;
        clear_overrun = 1'b0;
        check("clear_overrun_flags", 32'(overrun), 0);
        check("clear_overrun_cnt", overrun_cnt, 0);
    endtask

    // Demodulator model: result strobe is sampled by the arbiter D cycles after load_tick rises.
    initial begin
        logic [BITS-1:0] m;
        demod_tick = 1'b0;
        demod_in   = '0;
        forever begin
            @(posedge CLK); #1;
            if (demod_load_tick === 1'b1 && demod_rstb === 1'b1 && !demod_hang) begin
                m = mag_of(demod_I, demod_Q);
                repeat (D - 1) @(posedge CLK);
                #1;
                demod_tick = 1'b1;
                demod_in   = m;
                @(posedge CLK); #1;
                demod_tick = 1'b0;
            end
        end
    end

    // Output monitor / scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK); #1;
            if (out_valid === 1'b1) begin
                if (flood) begin
                    check("flood_ch", 32'(out_ch), 1);
                    check("flood_sample", 32'(out_sample), 32'(flood_exp));
                end else if (exp_q.size() == 0) begin
                    check("spurious_out_valid", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_ch", 32'(out_ch), 32'(e.ch));
                    check("out_sample", 32'(out_sample), 32'(e.mag));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int k;
        RSTb = 1'b0;
        ch_I = '0;
        ch_Q = '0;
        ch_tick = '0;
        clear_overrun = 1'b0;
        do_reset();

        check("rst_busy", 32'(busy), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_overrun", 32'(overrun), 0);
        check("rst_overrun_cnt", overrun_cnt, 0);
        check("rst_demod_rstb", 32'(demod_rstb), 1);
        check("rst_load_tick", 32'(demod_load_tick), 0);
        check("rst_demod_I", 32'(demod_I), 0);
        check("rst_out_sample", 32'(out_sample), 0);
        check("rst_timeout_err", 32'(timeout_err), 0);

        // Fairness: all channels at once right after reset.
        set_s(0, 8'd10, 8'd3);
        set_s(1, 8'hEC, 8'd5);
        set_s(2, 8'd7, 8'hF9);
        set_s(3, 8'd100, 8'd27);
        for (int c = 0; c < NCH; c++) push(c, ch_I[c*BITS_IN +: BITS_IN], ch_Q[c*BITS_IN +: BITS_IN]);
        pulse(4'hF);
        wait_drain(600);
        check("fair_overrun", 32'(overrun), 0);

        // Single channel latency.
        set_s(2, 8'h80, 8'h00);
        push(2, 8'h80, 8'h00);
        ch_tick = 4'b0100;
        n = 0;
        while (n < 20) begin
            @(posedge CLK); #1;
            n++;
            ch_tick = '0;
            if (demod_load_tick) break;
        end
        check("load_latency", 32'(n), 3);
        check("single_demod_I", 32'(demod_I), 32'h80);
        check("single_demod_Q", 32'(demod_Q), 0);
        while (n < 100) begin
            @(posedge CLK); #1;
            n++;
            if (out_valid) break;
        end
        check("out_latency", 32'(n), D + 4);
        wait_drain(100);

        // Overrun while channel 0 is being demodulated.
        set_s(0, 8'd50, 8'd50);
        push(0, 8'd50, 8'd50);
        pulse(4'b0001);
        repeat (4) @(posedge CLK);
        #1;
        set_s(1, 8'd1, 8'd2);
        pulse(4'b0010);
        set_s(1, 8'd30, 8'd40);
        pulse(4'b0010);
        push(1, 8'd30, 8'd40);
        check("overrun_flag", 32'(overrun), 32'b0010);
`ifdef AM_ARB_OVERRUN_CNT_EN
        check("overrun_cnt_1", 32'(overrun_cnt[15:8]), 1);
`else
        check("overrun_cnt_off", overrun_cnt, 0);
`endif
        wait_drain(300);
        clear_flags();

        // clear_overrun coincident with a new overrun leaves the flag set.
        set_s(0, 8'd3, 8'd4);
        push(0, 8'd3, 8'd4);
        pulse(4'b0001);
        repeat (4) @(posedge CLK);
        #1;
        set_s(1, 8'd5, 8'd6);
        pulse(4'b0010);
        set_s(1, 8'd7, 8'd8);
        clear_overrun = 1'b1;
        pulse(4'b0010);
        clear_overrun = 1'b0;
        push(1, 8'd7, 8'd8);
        check("clear_vs_overrun", 32'(overrun), 32'b0010);
`ifdef AM_ARB_OVERRUN_CNT_EN
        check("clear_vs_overrun_cnt", 32'(overrun_cnt[15:8]), 1);
`endif
        wait_drain(300);
        clear_flags();

        // Flood channel 1 for 300 cycles: counter saturates.
        set_s(1, 8'd9, 8'hFC);
        flood_exp = mag_of(8'd9, 8'hFC);
        flood = 1'b1;
        ch_tick = 4'b0010;
        repeat (300) @(posedge CLK);
        #1;
        ch_tick = '0;
        repeat (150) @(posedge CLK);
        #1;
        flood = 1'b0;
        check("flood_overrun", 32'(overrun), 32'b0010);
        check("flood_idle", 32'(busy), 0);
`ifdef AM_ARB_OVERRUN_CNT_EN
        check("flood_cnt_sat", 32'(overrun_cnt[15:8]), 255);
        check("flood_cnt_ch0", 32'(overrun_cnt[7:0]), 0);
`endif
        clear_flags();

        // Channel 3 ticks again in the very cycle it is granted.
        set_s(3, 8'd11, 8'd22);
        ch_tick = 4'b1000;
        @(posedge CLK); #1;
        set_s(3, 8'd33, 8'd44);
        @(posedge CLK); #1;
        ch_tick = '0;
        push(3, 8'd11, 8'd22);
        push(3, 8'd33, 8'd44);
        check("same_cycle_issued_I", 32'(demod_I), 11);
        wait_drain(300);
        check("same_cycle_overrun", 32'(overrun), 0);

        // Timeout: demodulator never answers for channel 0; channel 2 is served afterwards.
        demod_hang = 1'b1;
        set_s(0, 8'd5, 8'd5);
        set_s(2, 8'd60, 8'd70);
        pulse(4'b0001);
        n = 0;
        while (n < 10 && !demod_load_tick) begin
            @(posedge CLK); #1;
            n++;
        end
        check("to_load_seen", 32'(demod_load_tick), 1);
        n = 0;
        while (n < TIMEOUT + 20) begin
            @(posedge CLK); #1;
            n++;
            if (n == 5) ch_tick = 4'b0100;
            if (n == 6) ch_tick = '0;
            if (timeout_err) break;
        end
        push(2, 8'd60, 8'd70);
        check("timeout_latency", 32'(n), TIMEOUT + 1);
        check("timeout_rstb_low", 32'(demod_rstb), 0);
        demod_hang = 1'b0;
        k = 1;
        for (int j = 0; j < 10; j++) begin
            @(posedge CLK); #1;
            if (demod_rstb) break;
            k++;
        end
        check("rstb_low_cycles", 32'(k), 2);
        check("timeout_pulse_width", 32'(timeout_err), 0);
        wait_drain(300);

        // Reset in the middle of ARB_WAIT; the late demod result must be ignored.
        set_s(1, 8'd77, 8'd1);
        pulse(4'b0010);
        n = 0;
        while (n < 10 && !demod_load_tick) begin
            @(posedge CLK); #1;
            n++;
        end
        repeat (5) @(posedge CLK);
        #1;
        RSTb = 1'b0;
        @(posedge CLK); #1;
        check("midrst_out_valid", 32'(out_valid), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_demod_rstb", 32'(demod_rstb), 0);
        check("midrst_demod_I", 32'(demod_I), 0);
        RSTb = 1'b1;
        repeat (D + 10) @(posedge CLK);
        #1;
        check("midrst_after_busy", 32'(busy), 0);
        check("midrst_after_sample", 32'(out_sample), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
